// File: rtl/dcm_fx_synth_pkg.sv
// Shared constants and helpers for the DCM-replacement clock-enable synthesiser.
package dcm_fx_synth_pkg;

  localparam int FX_M_MAX     = 32;
  localparam int FX_D_MAX     = 32;
  localparam int FX_M_DEFAULT = 25;
  localparam int FX_D_DEFAULT = 32;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dcm_fx_synth_phase_acc.sv
// Bresenham phase accumulator: emits M single-cycle pulses per D enabled cycles.
module fx_phase_acc
  import dcm_fx_synth_pkg::*;
#(
  parameter int M = FX_M_DEFAULT,
  parameter int D = FX_D_DEFAULT
) (
  input  logic CLKIN,
  input  logic RST_N,
  input  logic en,
  output logic pulse
);

  localparam int AW = clog2(D) + 1;
  localparam logic [AW:0] M_EXT = M[AW:0];
  localparam logic [AW:0] D_EXT = D[AW:0];

  logic [AW-1:0] r_acc;
  logic [AW:0]   w_sum;
  logic [AW:0]   w_diff;
  logic          w_wrap;

  // One bit wider than the accumulator so acc+M can never overflow.
  assign w_sum  = {1'b0, r_acc} + M_EXT;
  assign w_diff = w_sum - D_EXT;
  assign w_wrap = (w_sum >= D_EXT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLKIN or negedge RST_N) begin
    if (!RST_N) begin
      r_acc <= '0;
      pulse <= 1'b0;
    end else if (en) begin
      r_acc <= w_wrap ? w_diff[AW-1:0] : w_sum[AW-1:0];
      pulse <= w_wrap;
    end else begin
      r_acc <= '0;
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/dcm_fx_synth.sv
// Synthesizable DCM stand-in: CLK0 pass-through, lock timer, and M/D CLKFX enable stream.
module dcm_fx_synth
  import dcm_fx_synth_pkg::*;
#(
  parameter int CLKFX_MULTIPLY = FX_M_DEFAULT,
  parameter int CLKFX_DIVIDE   = FX_D_DEFAULT,
  parameter int LOCK_CYCLES    = 16
) (
  input  logic CLKIN,
  input  logic RST_N,
  input  logic CLKFB,
  output logic CLK0,
  output logic CLKFX,
  output logic LOCKED
);

  localparam int LW = clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_TARGET = LOCK_CYCLES[LW-1:0];
  localparam logic [LW-1:0] LOCK_LAST   = LOCK_TARGET - 1'b1;

  generate
    if (CLKFX_MULTIPLY < 1 || CLKFX_MULTIPLY > FX_M_MAX) begin : g_bad_m
      $error("dcm_fx_synth: CLKFX_MULTIPLY out of range 1..32");
    end
    if (CLKFX_DIVIDE < 1 || CLKFX_DIVIDE > FX_D_MAX) begin : g_bad_d
      $error("dcm_fx_synth: CLKFX_DIVIDE out of range 1..32");
    end
    if (CLKFX_MULTIPLY > CLKFX_DIVIDE) begin : g_bad_ratio
      $error("dcm_fx_synth: CLKFX_MULTIPLY must not exceed CLKFX_DIVIDE");
    end
    if (LOCK_CYCLES < 1) begin : g_bad_lock
      $error("dcm_fx_synth: LOCK_CYCLES must be at least 1");
    end
  endgenerate

  logic [LW-1:0] r_lock_cnt;
  logic          r_locked;
  logic          w_unused_fb;

  // Feedback is kept only so the port list matches the vendor primitive.
  assign w_unused_fb = CLKFB;
  assign CLK0        = CLKIN;
  assign LOCKED      = r_locked;

  always_ff @(posedge CLKIN or negedge RST_N) begin
    if (!RST_N) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else begin
      if (r_lock_cnt != LOCK_TARGET) begin
        r_lock_cnt <= r_lock_cnt + 1'b1;
      end
      // Assert on the same edge the counter reaches its target; sticky until reset.
      if (r_lock_cnt == LOCK_LAST) begin
        r_locked <= 1'b1;
      end
    end
  end

  fx_phase_acc #(
    .M(CLKFX_MULTIPLY),
    .D(CLKFX_DIVIDE)
  ) u_phase_acc (
    .CLKIN(CLKIN),
    .RST_N(RST_N),
    .en   (r_locked),
    .pulse(CLKFX)
  );

endmodule

// File: tb/tb_dcm_fx_synth.sv
// Directed bench for dcm_fx_synth: lock timing, 25/32, 1/32 and 8/8 ratios, async reset, CLK0/CLKFB.
module tb_dcm_fx_synth;

  logic clk;
  logic rst_n;
  logic clkfb;

  logic clk0_def, fx_def, lk_def;
  logic clk0_m1,  fx_m1,  lk_m1;
  logic clk0_m8,  fx_m8,  lk_m8;

  int checks;
  int failures;

  // Hand-derived 25/32 sequence for locked cycles 1..32, starting from acc = 0.
  localparam logic [1:32] PAT = 32'b0111_0111_1011_1011_1101_1101_1110_1111;

  dcm_fx_synth u_def (
    .CLKIN(clk), .RST_N(rst_n), .CLKFB(clkfb),
    .CLK0(clk0_def), .CLKFX(fx_def), .LOCKED(lk_def)
  );

  dcm_fx_synth #(.CLKFX_MULTIPLY(1), .CLKFX_DIVIDE(32), .LOCK_CYCLES(16)) u_m1 (
    .CLKIN(clk), .RST_N(rst_n), .CLKFB(clkfb),
    .CLK0(clk0_m1), .CLKFX(fx_m1), .LOCKED(lk_m1)
  );

  dcm_fx_synth #(.CLKFX_MULTIPLY(8), .CLKFX_DIVIDE(8), .LOCK_CYCLES(16)) u_m8 (
    .CLKIN(clk), .RST_N(rst_n), .CLKFB(clkfb),
    .CLK0(clk0_m8), .CLKFX(fx_m8), .LOCKED(lk_m8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset(input int ncyc);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (ncyc) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Leaves the bench at the negedge after release edge 16 (LOCKED just asserted).
  task automatic lock_up();
    apply_reset(5);
    repeat (16) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({fx_def, lk_def, fx_m1, lk_m1, fx_m8, lk_m8} !== 6'b0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: outputs=%b expected 000000", i,
                 {fx_def, lk_def, fx_m1, lk_m1, fx_m8, lk_m8});
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (lk_def !== (k == 16) || lk_m8 !== (k == 16)) begin
        failures++;
        $display("FAIL lock_edge[%0d]: locked=%b/%b expected %b", k, lk_def, lk_m8, k == 16);
      end
      checks++;
      if (fx_def !== 1'b0 || fx_m8 !== 1'b0) begin
        failures++;
        $display("FAIL fx_before_lock[%0d]: clkfx=%b/%b expected 0", k, fx_def, fx_m8);
      end
    end
    @(negedge clk);
    checks++;
    if (fx_m8 !== 1'b1 || fx_def !== 1'b0) begin
      failures++;
      $display("FAIL fx_edge17: clkfx m8=%b def=%b expected m8=1 def=0", fx_m8, fx_def);
    end
  endtask

  task automatic check_default_pattern(input string tag, input int ncyc);
    int cnt;
    cnt = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      checks++;
      if (fx_def !== PAT[((c - 1) % 32) + 1]) begin
        failures++;
        $display("FAIL %s[%0d]: clkfx=%b expected %b", tag, c, fx_def, PAT[((c - 1) % 32) + 1]);
      end
      if (c > ncyc - 32 && fx_def === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 25) begin
      failures++;
      $display("FAIL %s_window: pulses=%0d expected 25", tag, cnt);
    end
  endtask

  task automatic test_default_ratio();
    lock_up();
    check_default_pattern("ratio_25_32", 64);
  endtask

  task automatic test_m1();
    int cnt;
    cnt = 0;
    lock_up();
    for (int c = 1; c <= 96; c++) begin
      @(negedge clk);
      checks++;
      if (fx_m1 !== ((c % 32) == 0)) begin
        failures++;
        $display("FAIL ratio_1_32[%0d]: clkfx=%b expected %b", c, fx_m1, (c % 32) == 0);
      end
      if (fx_m1 === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 3) begin
      failures++;
      $display("FAIL ratio_1_32_count: pulses=%0d expected 3", cnt);
    end
  endtask

  task automatic test_m_eq_d();
    lock_up();
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if (fx_m8 !== 1'b1 || lk_m8 !== 1'b1) begin
        failures++;
        $display("FAIL ratio_8_8[%0d]: clkfx=%b locked=%b expected 1/1", c, fx_m8, lk_m8);
      end
    end
  endtask

  task automatic test_async_reset();
    lock_up();
    check_default_pattern_short();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fx_def, lk_def, fx_m8, lk_m8, lk_m1} !== 5'b0) begin
      failures++;
      $display("FAIL async_clear: outputs=%b expected 00000", {fx_def, lk_def, fx_m8, lk_m8, lk_m1});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (lk_def !== (k == 16) || fx_def !== 1'b0) begin
        failures++;
        $display("FAIL relock[%0d]: locked=%b clkfx=%b expected %b/0", k, lk_def, fx_def, k == 16);
      end
    end
    check_default_pattern("restart", 32);
  endtask

  // Ten locked cycles before the mid-run reset; M=D instance must be high by then.
  task automatic check_default_pattern_short();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (fx_def !== PAT[c] || fx_m8 !== 1'b1) begin
        failures++;
        $display("FAIL prereset[%0d]: def=%b m8=%b expected %b/1", c, fx_def, fx_m8, PAT[c]);
      end
    end
  endtask

  task automatic test_clk0_fb();
    logic fb_vals [3];
    fb_vals[0] = 1'b0;
    fb_vals[1] = 1'b1;
    fb_vals[2] = 1'bx;
    @(negedge clk);
    rst_n = 1'b0;
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #2;
        checks++;
        if ({clk0_def, clk0_m1, clk0_m8} !== 3'b111) begin
          failures++;
          $display("FAIL clk0_high[%0d.%0d]: clk0=%b expected 111", phase, i, {clk0_def, clk0_m1, clk0_m8});
        end
        @(negedge clk);
        #2;
        checks++;
        if ({clk0_def, clk0_m1, clk0_m8} !== 3'b000) begin
          failures++;
          $display("FAIL clk0_low[%0d.%0d]: clk0=%b expected 000", phase, i, {clk0_def, clk0_m1, clk0_m8});
        end
      end
      rst_n = 1'b1;
    end
    for (int v = 0; v < 3; v++) begin
      clkfb = fb_vals[v];
      lock_up();
      check_default_pattern($sformatf("clkfb_%0d", v), 32);
    end
    clkfb = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    clkfb    = 1'b0;
    test_reset();
    test_default_ratio();
    test_m1();
    test_m_eq_d();
    test_async_reset();
    test_clk0_fb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
